// File: rtl/instr_buffer_pkg.sv
// Shared types and constants for the instruction buffer.
// Entry layout is {valid, is_jump, pc[31:0], instr[31:0]}.
package instr_buffer_pkg;

  localparam int IB_WIDTH_LOG2  = 4;
  localparam int IB_DATA_BUS_WD = 66;
  localparam int IB_DEPTH       = 1 << IB_WIDTH_LOG2;
  localparam int IB_PUSH_PORTS  = 4;
  localparam int IB_READ_PORTS  = 2;

  localparam int VALID_BIT = 65;
  localparam int JUMP_BIT  = 64;
  localparam int PC_LSB    = 32;
  localparam int INSTR_LSB = 0;

  typedef logic [IB_WIDTH_LOG2-1:0]  ib_ptr_t;
  typedef logic [IB_WIDTH_LOG2:0]    ib_cnt_t;
  typedef logic [IB_DATA_BUS_WD-1:0] ib_data_t;

  typedef struct packed {
    logic        valid;
    logic        is_jump;
    logic [31:0] pc;
    logic [31:0] instr;
  } ib_entry_t;

  function automatic ib_ptr_t ptr_add(ib_ptr_t p, int unsigned n);
    return p + ib_ptr_t'(n);
  endfunction

endpackage

// File: rtl/instr_buffer_if.sv
// Fetch/decode side bundle of the instruction buffer.
// slave = buffer side, master = fetch + decode side.
interface instr_buffer_if;
  import instr_buffer_pkg::*;

  logic                                  flush_IB;
  logic [IB_PUSH_PORTS*IB_DATA_BUS_WD-1:0] if1_to_ib;
  logic [2:0]                            push_num;
  ib_cnt_t                               can_push_size;
  logic [IB_READ_PORTS*IB_DATA_BUS_WD-1:0] ib_to_id;
  logic [1:0]                            ib_valid;
  logic [1:0]                            id_pop_num;

  modport slave (
    input  flush_IB,
    input  if1_to_ib,
    input  push_num,
    input  id_pop_num,
    output can_push_size,
    output ib_to_id,
    output ib_valid
  );

  modport master (
    output flush_IB,
    output if1_to_ib,
    output push_num,
    output id_pop_num,
    input  can_push_size,
    input  ib_to_id,
    input  ib_valid
  );

endinterface

// File: rtl/instr_buffer_ib_regfile.sv
// Entry storage: 4 write ports at consecutive addresses
// from a base, 2 combinational reads at raddr and raddr+1.
module ib_regfile
  import instr_buffer_pkg::*;
(
  input  logic                          clk,
  input  logic [IB_PUSH_PORTS-1:0]      we,
  input  ib_ptr_t                       waddr,
  input  logic [IB_PUSH_PORTS-1:0][IB_DATA_BUS_WD-1:0] wdata,
  input  ib_ptr_t                       raddr,
  output ib_data_t                      rdata0,
  output ib_data_t                      rdata1
);

  ib_data_t mem_q [IB_DEPTH];
  ib_data_t mem_d [IB_DEPTH];

  // merge this cycle's writes; addresses wrap with the pointer width
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < IB_PUSH_PORTS; i++) begin
      if (we[i]) begin
        mem_d[ptr_add(waddr, i)] = wdata[i];
      end
    end
  end

  // storage has no reset; occupancy decides what is meaningful
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata0 = mem_q[raddr];
  assign rdata1 = mem_q[ptr_add(raddr, 1)];

endmodule

// File: rtl/instr_buffer.sv
// Circular instruction buffer between fetch and decode.
// Takes 0-4 entries per cycle, hands the two oldest to decode.
module instr_buffer
  import instr_buffer_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  instr_buffer_if.slave ib
);

  ib_ptr_t head_q, head_d;
  ib_ptr_t tail_q, tail_d;
  ib_cnt_t count_q, count_d;

  logic [IB_PUSH_PORTS-1:0] we;
  logic [IB_PUSH_PORTS-1:0][IB_DATA_BUS_WD-1:0] wdata;
  ib_data_t rdata0, rdata1;

  assign wdata = ib.if1_to_ib;

  // pointer/count update; flush drops same-cycle push and pop
  always_comb begin
    head_d  = ptr_add(head_q, 32'(ib.id_pop_num));
    tail_d  = ptr_add(tail_q, 32'(ib.push_num));
    count_d = count_q + ib_cnt_t'(ib.push_num)
                      - ib_cnt_t'(ib.id_pop_num);
    we      = '0;
    for (int i = 0; i < IB_PUSH_PORTS; i++) begin
      we[i] = (3'(i) < ib.push_num) && !ib.flush_IB;
    end
    if (ib.flush_IB) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  ib_regfile u_rf (
    .clk    (clk),
    .we     (we),
    .waddr  (tail_q),
    .wdata  (wdata),
    .raddr  (head_q),
    .rdata0 (rdata0),
    .rdata1 (rdata1)
  );

  assign ib.ib_to_id      = {rdata1, rdata0};
  assign ib.can_push_size = count_q;
  assign ib.ib_valid      = {count_q >= ib_cnt_t'(2),
                             count_q != '0};

endmodule

// File: tb/tb_instr_buffer.sv
// Self-checking bench for instr_buffer.
// Reference model is a queue of entries in arrival order.
module tb_instr_buffer;
  import instr_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_buffer_if ibif();

  instr_buffer dut (
    .clk (clk),
    .rst (rst),
    .ib  (ibif)
  );

  int checks = 0;
  int errors = 0;

  ib_data_t    mq[$];
  ib_data_t    slot[4];
  logic [31:0] next_pc;
  logic [31:0] wp;

  task automatic chk(string tag, logic [65:0] obs, logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ib_data_t mk();
    ib_entry_t e;
    e.valid   = 1'($urandom_range(0, 1));
    e.is_jump = 1'($urandom_range(0, 1));
    e.pc      = next_pc;
    e.instr   = $urandom;
    next_pc   = next_pc + 32'd4;
    return e;
  endfunction

  function automatic int fit(int n);
    if (mq.size() + n >= IB_DEPTH) return 0;
    return n;
  endfunction

  task automatic drive(int n, int p, bit fl);
    for (int i = 0; i < 4; i++) begin
      if (i < n) slot[i] = mk();
      else slot[i] = {$urandom, $urandom, 2'($urandom)};
    end
    ibif.if1_to_ib  = {slot[3], slot[2], slot[1], slot[0]};
    ibif.push_num   = 3'(n);
    ibif.id_pop_num = 2'(p);
    ibif.flush_IB   = fl;
  endtask

  function automatic logic [31:0] pc0();
    return ibif.ib_to_id[PC_LSB +: 32];
  endfunction

  function automatic logic [31:0] pc1();
    return ibif.ib_to_id[IB_DATA_BUS_WD + PC_LSB +: 32];
  endfunction

  task automatic check_all(string tag);
    int sz;
    sz = mq.size();
    chk({tag, "_cnt"}, 66'(ibif.can_push_size), 66'(sz));
    chk({tag, "_vld"}, 66'(ibif.ib_valid),
        66'({sz >= 2, sz >= 1}));
    if (sz >= 1)
      chk({tag, "_s0"}, 66'(ibif.ib_to_id[IB_DATA_BUS_WD-1:0]), mq[0]);
    if (sz >= 2)
      chk({tag, "_s1"},
          66'(ibif.ib_to_id[2*IB_DATA_BUS_WD-1:IB_DATA_BUS_WD]), mq[1]);
  endtask

  task automatic step(string tag);
    int n, p;
    n = int'(ibif.push_num);
    p = int'(ibif.id_pop_num);
    if (!rst && !ibif.flush_IB) begin
      if (n != 0)
        chk({tag, "_pushfit"},
            66'(int'(ibif.can_push_size) + n < IB_DEPTH), 66'(1));
      if (p != 0)
        chk({tag, "_popok"},
            66'(p <= int'(ibif.ib_valid[0]) + int'(ibif.ib_valid[1])),
            66'(1));
    end
    @(posedge clk);
    if (rst || ibif.flush_IB) begin
      mq.delete();
    end else begin
      for (int i = 0; i < p; i++) void'(mq.pop_front());
      for (int i = 0; i < n; i++) mq.push_back(slot[i]);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    rst     = 1'b1;
    next_pc = 32'h1c00_0000;
    drive(0, 0, 1'b0);
    step("rst0");
    step("rst1");
    chk("rst_cnt", 66'(ibif.can_push_size), 66'(0));
    chk("rst_vld", 66'(ibif.ib_valid), 66'(0));
    rst = 1'b0;

    drive(3, 0, 1'b0);
    step("push3");
    chk("push3_cnt", 66'(ibif.can_push_size), 66'(3));
    chk("push3_vld", 66'(ibif.ib_valid), 66'(2'b11));
    chk("push3_pc0", 66'(pc0()), 66'(32'h1c00_0000));
    chk("push3_pc1", 66'(pc1()), 66'(32'h1c00_0004));

    drive(0, 2, 1'b0);
    step("pop2");
    chk("pop2_cnt", 66'(ibif.can_push_size), 66'(1));
    chk("pop2_vld", 66'(ibif.ib_valid), 66'(2'b01));
    chk("pop2_pc0", 66'(pc0()), 66'(32'h1c00_0008));

    drive(4, 1, 1'b0);
    step("p4p1");
    chk("p4p1_cnt", 66'(ibif.can_push_size), 66'(4));
    chk("p4p1_pc0", 66'(pc0()), 66'(32'h1c00_000c));

    // bring head and tail to 14 with an empty buffer
    drive(0, 0, 1'b1); step("fl0");
    drive(4, 0, 1'b0); step("adv0");
    drive(4, 2, 1'b0); step("adv1");
    drive(4, 2, 1'b0); step("adv2");
    drive(2, 2, 1'b0); step("adv3");
    for (int i = 0; i < 4; i++) begin
      drive(0, 2, 1'b0); step("drain");
    end
    chk("adv_cnt", 66'(ibif.can_push_size), 66'(0));

    wp = next_pc;
    drive(4, 0, 1'b0);
    step("wrap");
    chk("wrap_cnt", 66'(ibif.can_push_size), 66'(4));
    chk("wrap_pc0", 66'(pc0()), 66'(wp));
    drive(0, 1, 1'b0);
    step("wrap_h15");
    chk("wrap_h15_pc1", 66'(pc1()), 66'(wp + 32'd8));
    drive(0, 2, 1'b0);
    step("wrap_d2");
    chk("wrap_d2_pc0", 66'(pc0()), 66'(wp + 32'd12));
    drive(0, 1, 1'b0);
    step("wrap_d1");

    for (int i = 0; i < 3; i++) begin
      drive(fit(4), 0, 1'b0); step("fill");
    end
    chk("fill12_cnt", 66'(ibif.can_push_size), 66'(12));
    drive(fit(4), 0, 1'b0);
    step("fill_hold");
    chk("fill_hold_cnt", 66'(ibif.can_push_size), 66'(12));
    drive(fit(3), 0, 1'b0);
    step("fill15");
    chk("fill15_cnt", 66'(ibif.can_push_size), 66'(15));
    chk("fill15_vld", 66'(ibif.ib_valid), 66'(2'b11));

    drive(0, 2, 1'b0); step("dr");
    drive(0, 2, 1'b0); step("dr");
    drive(0, 2, 1'b0); step("dr");
    drive(0, 1, 1'b0); step("dr");
    chk("pre_fl_cnt", 66'(ibif.can_push_size), 66'(8));
    drive(4, 2, 1'b1);
    step("flush");
    chk("flush_cnt", 66'(ibif.can_push_size), 66'(0));
    chk("flush_vld", 66'(ibif.ib_valid), 66'(0));
    wp = next_pc;
    drive(1, 0, 1'b0);
    step("post_fl");
    chk("post_fl_vld", 66'(ibif.ib_valid), 66'(2'b01));
    chk("post_fl_pc0", 66'(pc0()), 66'(wp));

    for (int k = 0; k < 400; k++) begin
      int n, p, mx;
      bit fl;
      fl = ($urandom_range(0, 24) == 0);
      n  = fit($urandom_range(0, 4));
      mx = (mq.size() < 2) ? mq.size() : 2;
      p  = $urandom_range(0, mx);
      drive(n, p, fl);
      step("rand");
    end

    drive(0, 0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_buffer.md
# instr_buffer

Instruction buffer between the second fetch stage and decode. It absorbs 0–4 fetched instruction entries per cycle and holds them in a circular FIFO of 2^`IB_WIDTH_LOG2` entries. It presents the two oldest entries to the dual-issue decoder, which retires 0–2 of them per cycle. It also reports its occupancy back to fetch, which uses that count to decide whether a push fits.

## Interface
Parameters (values come from `define.v`):
- `IB_WIDTH_LOG2`, default 4: log2 of buffer depth; depth = 16.
- `IB_DATA_BUS_WD`, default 66: entry width, packed as {valid, is_jump, pc[31:0], instr[31:0]}.

Ports:
- `clk`  in  1  clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `flush_IB`  in  1  discard all entries (branch redirect or exception).
- `if1_to_ib`  in  4*`IB_DATA_BUS_WD`  up to 4 entries; slot 0 is the oldest (lowest bits).
- `push_num`  in  3  number of leading slots to enqueue this cycle, 0..4.
- `can_push_size`  out  `IB_WIDTH_LOG2`+1  current occupancy, registered.
- `ib_to_id`  out  2*`IB_DATA_BUS_WD`  head entry in slot 0, head+1 in slot 1.
- `ib_valid`  out  2  bit0 = occupancy ≥ 1; bit1 = occupancy ≥ 2.
- `id_pop_num`  in  2  entries consumed by decode this cycle, 0..2.

## Operation
- State:
  - `head` and `tail` pointers, each `IB_WIDTH_LOG2` bits, wrapping modulo depth.
  - `count`, `IB_WIDTH_LOG2`+1 bits.
  - Storage array of depth × `IB_DATA_BUS_WD`.
- Push:
  - Slots 0..`push_num`-1 are written to storage at `tail`, `tail`+1, … (mod depth).
  - `tail` then advances by `push_num`.
- Pop:
  - `head` advances by `id_pop_num`.
  - Popped entries are not cleared.
- Count update: `count` ← `count` + `push_num` − `id_pop_num`. Compute this at full width with no saturation.
- Legality contract:
  - Fetch issues a nonzero `push_num` only when `can_push_size` + `push_num` < depth. The buffer therefore never holds more than depth−1 entries.
  - Decode never pops more entries than `ib_valid` indicates.
  - A violation of either rule is a bench error (assertion). Behaviour under violation is undefined.
- Read outputs:
  - `ib_to_id` slot 0 = storage[`head`]; slot 1 = storage[`head`+1 mod depth].
  - Both are combinational from registered state.
  - Slot contents are don't-care where the matching `ib_valid` bit is 0.
- Flush:
  - `head`, `tail` and `count` reset to 0.
  - Flush has priority over any push or pop in the same cycle; those are dropped.
- Reset: same effect as flush.
  - After reset: `can_push_size`=0, `ib_valid`=2'b00, `ib_to_id` don't-care.
- The entry's `valid` bit is stored and forwarded unchanged. It does not affect occupancy; decode handles entries whose `valid` bit is 0.

## Timing
- Push to visible: an entry pushed in cycle N appears at `ib_to_id` in cycle N+1 at the earliest. There is no empty-buffer bypass.
- Pop: entries popped in cycle N are replaced at `ib_to_id` in cycle N+1.
- Simultaneous push and pop are fully supported in the same cycle, including when `count`=1 and the pop empties the old entry while the push refills.
- `can_push_size` reflects occupancy at the start of the cycle. Fetch's fit check is deliberately conservative because it ignores this cycle's pops.
- Wrap-around: a 4-entry push starting at `tail`=14 writes indices 14, 15, 0, 1. The read of head+1 at `head`=15 returns index 0.
- Flush in cycle N: `ib_valid`=0 in cycle N+1. A push in cycle N+1 is visible in cycle N+2.

## Structure
- Shared package / `define.v` holds:
  - `IB_WIDTH_LOG2` and `IB_DATA_BUS_WD`.
  - Entry field offsets (VALID_BIT, JUMP_BIT, PC_LSB, INSTR_LSB).
- Sub-module `ib_regfile`: depth × width storage with 4 write ports (consecutive addresses from a base plus per-port enable) and 2 combinational read ports.
- The top level holds the pointers, the count, and the flush/reset logic.

## Test plan
- Reset, then push 3 entries (pc 0x1c000000/04/08):
  - Next cycle: `can_push_size`=3, `ib_valid`=11, slot0 pc=0x1c000000, slot1 pc=0x1c000004.
- Pop 2 with no push:
  - Next cycle: count=1, `ib_valid`=01, slot0 pc=0x1c000008.
- Same-cycle push 4 and pop 1 starting from count=1:
  - Next cycle: count=4, head pc is the first pushed entry.
- Wrap-around:
  - Setup: advance `head` and `tail` to 14 with count=0, then push 4.
  - Required: `can_push_size`=4; draining 2+2 returns the entries in push order.
- Fill check:
  - Setup: bring count to 12, attempt push 4, which the bench's fetch model must hold back.
  - Required: pushing 3 reaches count=15. The assertion fires if the bench forces a push of 4.
- Flush with push 4 and pop 2 asserted in the same cycle at count=8:
  - Next cycle: count=0, `ib_valid`=00.
  - A later push of 1 appears after one cycle.
